// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory port, decode-side handshake and redirect.
interface fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  redirect_misaligned;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, redirect_misaligned,
    input  imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, redirect_misaligned,
    output imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single outstanding fetch, redirect and prefetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  entry_t        q_head, q_wdata;
  logic          issue, resp_push, head_pop;
  logic [CW:0]   occupancy;

  always_comb begin
    // In-flight response is reserved a slot, so a full queue never drops data.
    occupancy     = {1'b0, q_count} + (CW+1)'(inflight_q);
    issue         = !bus.redirect_valid && !q_full && (occupancy < (CW+1)'(FIFO_DEPTH));
    resp_push     = inflight_q && !bus.redirect_valid;
    head_pop      = !q_empty && bus.inst_ready && !bus.redirect_valid;
    q_wdata.pc    = inflight_pc_q;
    q_wdata.instr = bus.imem_rdata;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~{{(DATA_WIDTH-2){1'b0}}, PC_ALIGN_MASK};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + DATA_WIDTH'(INSTR_BYTES);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_queue #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (resp_push),
    .push_data (q_wdata),
    .pop       (head_pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // rst gates the strobes so they fall immediately, not at the next edge.
  assign bus.imem_req            = issue && !rst;
  assign bus.imem_addr           = fetch_pc_q;
  assign bus.inst_valid          = !q_empty;
  assign bus.inst_data           = q_head.instr;
  assign bus.inst_pc             = q_head.pc;
  assign bus.redirect_misaligned = bus.redirect_valid && !rst &&
                                   (|(bus.redirect_pc[1:0] & PC_ALIGN_MASK));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.DATA_WIDTH(32)) bus ();
  fetch_if #(.DATA_WIDTH(32)) wbus ();

  fetch_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  always @(posedge clk) bus.imem_rdata  <= bus.imem_addr ^ K;
  always @(posedge clk) wbus.imem_rdata <= wbus.imem_addr ^ K;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t vt[25];

  task automatic setv(input int i, input logic ready, input logic rv, input logic [31:0] rpc,
                      input logic req, input logic [31:0] addr, input logic valid,
                      input logic [31:0] pc, input logic mis);
    vt[i] = '{ready, rv, rpc, req, addr, valid, pc, mis};
  endtask

  logic [31:0] wrap_addr[4];
  logic [31:0] exp_pc;

  initial begin
    // stall from reset: 4 requests then hold
    setv(0,  0, 0, 0,        1, 32'h000, 0, 0,       0);
    setv(1,  0, 0, 0,        1, 32'h004, 0, 0,       0);
    setv(2,  0, 0, 0,        1, 32'h008, 1, 32'h000, 0);
    setv(3,  0, 0, 0,        1, 32'h00C, 1, 32'h000, 0);
    for (int i = 4; i < 10; i++) setv(i, 0, 0, 0, 0, 32'h010, 1, 32'h000, 0);
    // drain then stream at 1/cycle
    setv(10, 1, 0, 0,        0, 32'h010, 1, 32'h000, 0);
    setv(11, 1, 0, 0,        1, 32'h010, 1, 32'h004, 0);
    setv(12, 1, 0, 0,        1, 32'h014, 1, 32'h008, 0);
    setv(13, 1, 0, 0,        1, 32'h018, 1, 32'h00C, 0);
    setv(14, 1, 0, 0,        1, 32'h01C, 1, 32'h010, 0);
    setv(15, 1, 0, 0,        1, 32'h020, 1, 32'h014, 0);
    // 3 entries + one in flight, then redirect to 0x100
    setv(16, 0, 0, 0,        1, 32'h024, 1, 32'h018, 0);
    setv(17, 0, 1, 32'h100,  0, 32'h028, 1, 32'h018, 0);
    setv(18, 1, 0, 0,        1, 32'h100, 0, 0,       0);
    setv(19, 1, 0, 0,        1, 32'h104, 0, 0,       0);
    setv(20, 1, 0, 0,        1, 32'h108, 1, 32'h100, 0);
    // misaligned redirect
    setv(21, 1, 1, 32'h102,  0, 32'h10C, 1, 32'h104, 1);
    setv(22, 1, 0, 0,        1, 32'h100, 0, 0,       0);
    setv(23, 1, 0, 0,        1, 32'h104, 0, 0,       0);
    setv(24, 1, 0, 0,        1, 32'h108, 1, 32'h100, 0);

    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    wrap_addr[3] = 32'h0000_0004;

    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    wbus.inst_ready     = 1'b1;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset imem_req", 32'(bus.imem_req), 32'd0);
    chk("reset inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("reset misaligned", 32'(bus.redirect_misaligned), 32'd0);
    chk("reset imem_addr", bus.imem_addr, 32'h0);
    chk("reset wrap imem_addr", wbus.imem_addr, 32'hFFFF_FFF8);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      bus.inst_ready     = vt[i].ready;
      bus.redirect_valid = vt[i].rv;
      bus.redirect_pc    = vt[i].rpc;
      #1;
      chk($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(vt[i].req));
      chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vt[i].addr);
      chk($sformatf("v%0d inst_valid", i), 32'(bus.inst_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d misaligned", i), 32'(bus.redirect_misaligned), 32'(vt[i].mis));
      if (vt[i].valid) begin
        chk($sformatf("v%0d inst_pc", i), bus.inst_pc, vt[i].pc);
        chk($sformatf("v%0d inst_data", i), bus.inst_data, vt[i].pc ^ K);
      end
      if (i < 4) begin
        chk($sformatf("wrap%0d imem_req", i), 32'(wbus.imem_req), 32'd1);
        chk($sformatf("wrap%0d imem_addr", i), wbus.imem_addr, wrap_addr[i]);
      end
      if (i == 2 || i == 3) begin
        chk($sformatf("wrap%0d inst_pc", i), wbus.inst_pc, wrap_addr[i-2]);
        chk($sformatf("wrap%0d inst_data", i), wbus.inst_data, wrap_addr[i-2] ^ K);
      end
    end

    // fill the queue, then reset mid-stream
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (6) begin
      @(negedge clk);
      bus.inst_ready = 1'b0;
    end
    #1;
    chk("full imem_req", 32'(bus.imem_req), 32'd0);
    chk("full inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("full inst_pc", bus.inst_pc, 32'h104);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async rst imem_req", 32'(bus.imem_req), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("restart%0d imem_addr", k), bus.imem_addr, 32'(4 * k));
      chk($sformatf("restart%0d inst_valid", k), 32'(bus.inst_valid), 32'(k >= 2));
      if (bus.inst_valid) begin
        chk($sformatf("restart%0d inst_pc", k), bus.inst_pc, exp_pc);
        chk($sformatf("restart%0d inst_data", k), bus.inst_data, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end, the successor to the single-cycle PC register, +4 adder and branch mux. It owns the program counter, issues sequential word fetches to a synchronous instruction memory, and buffers returned {pc, instruction} pairs in a prefetch queue behind a valid/ready handshake. It also accepts a one-cycle redirect (branch/jump target) that flushes all buffered and in-flight fetches. It sits between instruction memory and the decode/control stage of the core.

## Interface
- DATA_WIDTH, 32: PC and instruction width.
- FIFO_DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] are zero.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  DATA_WIDTH  fetch address; always word aligned.
- imem_rdata  in  DATA_WIDTH  instruction; valid exactly one cycle after the matching imem_req.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  consumer accepts head.
- inst_data  out  DATA_WIDTH  head instruction.
- inst_pc  out  DATA_WIDTH  head instruction address.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  DATA_WIDTH  redirect target.
- redirect_misaligned  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

## Operation
- State: fetch PC register, in-flight flag plus its address, queue of FIFO_DEPTH {pc, instr} entries, and count.
- Request rule: imem_req = !redirect_valid && (count + inflight < FIFO_DEPTH). imem_addr = fetch PC. Pop credit is not counted.
- On an issued request: inflight <= 1, in-flight address <= fetch PC, fetch PC <= fetch PC + 4. Addition is modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- Response: in the cycle after a request, imem_rdata is written to the tail with the in-flight address. inflight clears unless a new request is issued in the same cycle.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect, cycle N:
  - queue flushed (count = 0 at N+1);
  - the response arriving in N is discarded;
  - inflight cleared;
  - no request in N;
  - fetch PC <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  - redirect_misaligned = |redirect_pc[1:0], combinational in N.
- Simultaneous events: redirect beats pop and push. The pop is ignored and the consumer must treat the head as squashed.
- Queue full: no request is issued, because the occupancy rule guarantees space for every in-flight response. Queue empty: inst_valid = 0, and inst_data/inst_pc are don't-care.
- Reset asserted mid-operation: all state cleared immediately; any in-flight response is lost.

## Timing
- Reset values: fetch PC = RESET_PC, inflight = 0, count = 0, inst_valid = 0, imem_req = 0 while rst is high, redirect_misaligned = 0. inst_data/inst_pc are don't-care while inst_valid = 0.
- First request is in the first cycle after rst deasserts, at RESET_PC.
- Fetch-to-consume latency:
  - request in cycle C, data returns in C+1;
  - data is written to the queue at the end of C+1 and is visible at the head in C+2.
  - No fall-through path.
- Redirect in N: new target requested in N+1; first redirected instruction valid in N+3.
- Sustained throughput: 1 instruction/cycle with inst_ready held high.
- Combinational paths: only redirect_valid → imem_req and redirect_pc → redirect_misaligned. All other outputs are driven from registers.

## Structure
- Package fetch_pkg:
  - fetch_entry_t struct {pc, instr};
  - INSTR_BYTES = 4;
  - PC_ALIGN_MASK.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, a synchronous flush that takes priority, count, full and empty; parametrised by FIFO_DEPTH.
- fetch_unit holds the PC, in-flight tracking and redirect logic.

## Test plan
- Reset, then inst_ready=1, memory returning addr^32'hA5A5_0000: requests at 0, 4, 8, …. First inst_valid is in the 3rd cycle after reset release, with inst_pc=0 and inst_data=32'hA5A5_0000. One instruction/cycle thereafter.
- inst_ready=0 held for 10 cycles, FIFO_DEPTH=4: exactly 4 requests issued (0, 4, 8, C), count=4, imem_req=0 thereafter. After ready rises, PCs 0, 4, 8, C pop in order, then 10 follows with no gap.
- Redirect to 32'h0000_0100 while queue has 3 entries and a request is in flight: inst_valid=0 next cycle, stale response dropped, request at 0x100 next cycle, inst_pc=0x100 valid 3 cycles after the redirect.
- Redirect to 32'h0000_0102: redirect_misaligned pulses once and the fetch address is 0x100.
- RESET_PC=32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst asserted mid-stream with a full queue: inst_valid and imem_req drop asynchronously. After release, fetch restarts at RESET_PC and no pre-reset instruction ever appears at the head.
